// File: rtl/keycode_event_ctrl_if.sv
// Key event stream bundle: head-of-FIFO event plus consumer ready.
// master drives valid/code/type, slave drives ready.
interface keycode_event_ctrl_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic [1:0] evt_type;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_type,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_type,
    output evt_ready
  );
endinterface

// File: rtl/keycode_event_ctrl.sv
// Turns the PIO keycode into press/release/repeat events in a FWFT FIFO.
// Ports: clk, reset (async high), keycode_in, evt (event stream),
// held_code, fifo_count, overflow (sticky), clr_overflow.
module keycode_event_ctrl #(
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    keycode_in,
  keycode_event_ctrl_if.master          evt,
  output logic [7:0]                    held_code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam bit RPT_EN = (REPEAT_DELAY != 0);
  localparam logic [31:0] DLY_M1 =
    RPT_EN ? 32'(REPEAT_DELAY - 1) : 32'd0;
  localparam logic [31:0] RATE_M1 =
    (REPEAT_RATE > 0) ? 32'(REPEAT_RATE - 1) : 32'd0;

  localparam logic [1:0] T_PRESS = 2'b00;
  localparam logic [1:0] T_REL   = 2'b01;
  localparam logic [1:0] T_RPT   = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    SWAP
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic [1:0] kind;
  } evt_t;

  state_t      state, state_d;
  logic [7:0]  kc_q;
  logic [7:0]  held_d;
  logic [7:0]  pend, pend_d;
  logic [31:0] rpt_cnt, rpt_d;
  logic [31:0] rate_cnt, rate_d;
  logic        push;
  evt_t        push_evt;

  evt_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          empty, full;
  logic          pop, wr_en, drop;

  // Next-state and event generation; at most one push per cycle.
  always_comb begin
    state_d  = state;
    held_d   = held_code;
    pend_d   = pend;
    rpt_d    = rpt_cnt;
    rate_d   = rate_cnt;
    push     = 1'b0;
    push_evt = '0;
    unique case (state)
      IDLE: begin
        if (kc_q != 8'd0) begin
          push     = 1'b1;
          push_evt = '{code: kc_q, kind: T_PRESS};
          held_d   = kc_q;
          rpt_d    = '0;
          rate_d   = '0;
          state_d  = HELD;
        end
      end
      HELD: begin
        if (kc_q == held_code) begin
          if (rpt_cnt != '1)
            rpt_d = rpt_cnt + 32'd1;
          rate_d = rate_cnt + 32'd1;
          // First repeat at DLY_M1, then every RATE via the sub-counter,
          // which is only meaningful once the first repeat reloaded it.
          if (RPT_EN &&
              ((rpt_cnt == DLY_M1) ||
               ((rpt_cnt > DLY_M1) && (rate_cnt == RATE_M1)))) begin
            push     = 1'b1;
            push_evt = '{code: held_code, kind: T_RPT};
            rate_d   = '0;
          end
        end else if (kc_q == 8'd0) begin
          push     = 1'b1;
          push_evt = '{code: held_code, kind: T_REL};
          held_d   = 8'd0;
          state_d  = IDLE;
        end else begin
          push     = 1'b1;
          push_evt = '{code: held_code, kind: T_REL};
          pend_d   = kc_q;
          held_d   = 8'd0;
          state_d  = SWAP;
        end
      end
      SWAP: begin
        push     = 1'b1;
        push_evt = '{code: pend, kind: T_PRESS};
        held_d   = pend;
        rpt_d    = '0;
        rate_d   = '0;
        state_d  = HELD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty = (fifo_count == '0);
  assign full  = (fifo_count == FULL_CNT);
  assign pop   = !empty && evt.evt_ready;
  // A pop in the same cycle frees the slot, so full only blocks alone.
  assign wr_en = push && (!full || pop);
  assign drop  = push && !wr_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      kc_q      <= 8'd0;
      held_code <= 8'd0;
      pend      <= 8'd0;
      rpt_cnt   <= '0;
      rate_cnt  <= '0;
    end else begin
      state     <= state_d;
      kc_q      <= keycode_in;
      held_code <= held_d;
      pend      <= pend_d;
      rpt_cnt   <= rpt_d;
      rate_cnt  <= rate_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

  // Storage needs no reset: the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= push_evt;
  end

  assign evt.evt_valid = !empty;
  assign evt.evt_code  = empty ? 8'd0 : mem[rd_ptr].code;
  assign evt.evt_type  = empty ? 2'd0 : mem[rd_ptr].kind;

endmodule

// File: doc/keycode_event_ctrl.md
Name: keycode_event_ctrl

Overview:
- Sequences the 8-bit keycode written by the NIOS into the keycode PIO (its out_port) into a stream of discrete key events (press / release / auto-repeat) for the game logic.
- Detects keycode changes, generates typematic repeat, and buffers events in a small FIFO behind a valid/ready handshake.
- Sits between the keycode PIO output and the player/menu control FSMs.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.
- REPEAT_DELAY, 25000000, cycles a key is held before the first repeat event; 0 disables repeat.
- REPEAT_RATE, 5000000, cycles between subsequent repeat events; must be ≥1 when REPEAT_DELAY≠0.

Ports:
- clk, in, 1, system clock (same domain as the PIO).
- reset, in, 1, asynchronous active-high reset.
- keycode_in, in, 8, current keycode from the PIO out_port; 0 means no key.
- evt_valid, out, 1, FIFO head holds an event.
- evt_ready, in, 1, consumer accepts the head this cycle.
- evt_code, out, 8, keycode of the head event.
- evt_type, out, 2, head event type: 00 press, 01 release, 10 repeat; 11 is never produced.
- held_code, out, 8, committed currently-held key; 0 if none.
- fifo_count, out, $clog2(FIFO_DEPTH)+1, number of buffered events.
- overflow, out, 1, sticky flag: an event was dropped.
- clr_overflow, in, 1, clears overflow.

Behaviour:
- Reset (asynchronous, while reset=1):
  - All outputs are 0, the FIFO is empty, kc_q=0, and the FSM is in IDLE.
  - Reset mid-operation discards all queued events and the repeat state.
- Input stage: kc_q <= keycode_in every cycle. All decisions use kc_q, never keycode_in.
- FSM states:
  - IDLE (held_code=0).
  - HELD (held_code≠0, repeat counter running).
  - SWAP (press pending after a release).
- IDLE:
  - If kc_q≠0: push press(kc_q), held_code<=kc_q, rpt_cnt<=0, go to HELD.
- HELD:
  - kc_q==held_code: rpt_cnt increments, saturating at 2^32-1.
    - If REPEAT_DELAY≠0 and rpt_cnt==REPEAT_DELAY-1, push repeat(held_code).
    - Thereafter push a repeat each time rpt_cnt reaches REPEAT_DELAY-1+k·REPEAT_RATE; implement with a rate sub-counter that reloads after each repeat.
  - kc_q==0: push release(held_code), held_code<=0, go to IDLE.
  - kc_q≠0 and ≠held_code: push release(held_code), latch pend<=kc_q, held_code<=0, go to SWAP.
- SWAP:
  - Push press(pend), held_code<=pend, rpt_cnt<=0, go to HELD.
  - Any further kc_q change is handled by HELD on the next cycle.
  - Consequence: a 1-cycle glitch A→B→A yields release A, press B, release B, press A.
- At most one push per cycle.
- Latency: keycode_in changes before edge E0, kc_q updates at E0, event pushed at E1, evt_valid=1 after E1 (FIFO previously empty).
  - For A→B, release is pushed at E1 and press at E2.
- FIFO:
  - First-word-fall-through: evt_code/evt_type show the head whenever evt_valid=1.
  - Pop occurs when evt_valid && evt_ready.
  - Pop on empty is ignored.
  - Push and pop in the same cycle:
    - count unchanged;
    - allowed even when full, because the pop frees the slot.
  - Push when full without pop:
    - the event is dropped and overflow<=1;
    - FSM state and held_code still advance normally.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_count ranges 0..FIFO_DEPTH.
- overflow:
  - Set has priority over clr_overflow in the same cycle.
  - Otherwise clr_overflow clears it.
- evt_type and evt_code are held stable while evt_valid=1 and evt_ready=0.

Test Plan:
- Bench parameters: REPEAT_DELAY=10, REPEAT_RATE=4, FIFO_DEPTH=4.
- Press/release: keycode_in 0→0x1A, hold 3 cycles, →0, evt_ready=1 → press 0x1A appears 2 cycles after the change; release 0x1A follows; held_code 0x1A then 0; overflow=0.
- Swap: keycode_in 0x04→0x16 directly → release 0x04 then press 0x16 on consecutive cycles; held_code 0x00 for exactly one cycle between them.
- Auto-repeat: hold 0x07 for 30 cycles, evt_ready=1 → press; then repeat events 10, 14, 18, 22, 26 cycles after the press commits; release on key-up.
- Backpressure/overflow: evt_ready=0, keycodes 0x04, 0x05, 0x06, 0 toggled → first 4 events retained in order, fifo_count=4, overflow=1; the head is held stable; draining yields the 4 events and fifo_count=0; clr_overflow clears overflow.
- Full with simultaneous push+pop: FIFO full, evt_ready=1 on the same cycle as a new event → no drop, overflow stays 0, fifo_count stays 4.
- Reset mid-repeat: hold 0x1A, FIFO holding 2 events, assert reset asynchronously → evt_valid, held_code, fifo_count, overflow all 0 immediately; after release with keycode 0x1A still present, a fresh press 0x1A is generated.
